// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding and the common default bit timing.
package uart_pkg;

    localparam int unsigned DefaultClksPerBit = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait
    } tx_sched_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority pick: first set bit of req at index ptr, ptr+1, ... modulo NUM_REQ.
module uart_rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       any,
    output logic [$clog2(NUM_REQ)-1:0] winner
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam logic [IdxW:0] NumReqW = (IdxW + 1)'(NUM_REQ);

    logic          found;
    logic [IdxW:0] idx;

    // One extra bit on idx so ptr + offset can wrap without overflowing.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + (IdxW + 1)'(i);
            if (idx >= NumReqW) begin
                idx = idx - NumReqW;
            end
            if (!found && req[idx[IdxW-1:0]]) begin
                found  = 1'b1;
                winner = idx[IdxW-1:0];
            end
        end
        any = found;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte requesters.
// Define UART_TX_SCHED_TIMEOUT_EN to enable the tx_done watchdog.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned CLKS_PER_BIT   = DefaultClksPerBit,
    parameter int unsigned TIMEOUT_CYCLES = CLKS_PER_BIT * 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0][7:0] req_data,
    output logic [NUM_REQ-1:0]      ack,
    output logic                    tx_dv,
    output logic [7:0]              tx_byte,
    input  logic                    tx_done,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    tx_sched_state_e state_q, state_d;

    logic [IdxW-1:0]    ptr_q, ptr_nxt;
    logic [IdxW-1:0]    winner;
    logic               any;
    logic               launch;
    logic               timeout_hit;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_dv_q;
    logic [7:0]         tx_byte_q;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (any),
        .winner (winner)
    );

    assign launch  = (state_q == StIdle) && any;
    assign ptr_nxt = (winner == IdxW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StSend) begin
            cnt_d = '0;
        end else if (state_q == StWait) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed WAIT cycles, so it reaches TIMEOUT_CYCLES at the end of this one.
    assign timeout_hit = (state_q == StWait) && !tx_done &&
                         (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any) begin
                    state_d = StSend;
                end
            end
            StSend: state_d = StWait;
            StWait: begin
                if (tx_done || timeout_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy        = (state_q != StIdle);
        timeout_err = timeout_hit;
        ack         = ack_q;
        tx_dv       = tx_dv_q;
        tx_byte     = tx_byte_q;
    end

    always_comb begin
        ack_d = '0;
        if (launch) begin
            ack_d[winner] = 1'b1;
        end
    end

    // Byte, ack and strobe are captured together on the IDLE->SEND edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q     <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            ptr_q     <= '0;
        end else begin
            ack_q   <= ack_d;
            tx_dv_q <= launch;
            if (launch) begin
                tx_byte_q <= req_data[winner];
                ptr_q     <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched with a transmitter model (tx_done 80 cycles after tx_dv).
module tb_uart_tx_sched;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req;
    logic [3:0][7:0] req_data;
    logic [3:0]      ack;
    logic            tx_dv;
    logic [7:0]      tx_byte;
    logic            tx_done;
    logic            busy;
    logic            timeout_err;

    logic model_done;
    logic force_done;
    bit   model_en;
    int   model_cnt;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   launch_cyc;
    int   mark_cyc;
    int   prev_cyc;
    bit   saw_to;

    uart_tx_sched #(
        .NUM_REQ      (4),
        .CLKS_PER_BIT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .tx_dv       (tx_dv),
        .tx_byte     (tx_byte),
        .tx_done     (tx_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign tx_done = model_done | force_done;

    // Transmitter model: tx_done rises 80 clock edges after tx_dv rises.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_cnt  <= 0;
            model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (model_cnt != 0) begin
                if (model_cnt == 79) begin
                    model_done <= 1'b1;
                    model_cnt  <= 0;
                end else begin
                    model_cnt <= model_cnt + 1;
                end
            end else if (tx_dv && model_en) begin
                model_cnt <= 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_launch(input string tag);
        int n = 0;
        while (tx_dv !== 1'b1 && n < 300) begin
            wait_clk();
            n++;
        end
        check({tag, "_dv"}, 32'(tx_dv), 32'd1);
        launch_cyc = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            wait_clk();
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        req        = 4'b0000;
        req_data   = '0;
        force_done = 1'b0;
        model_en   = 1'b1;
        repeat (3) wait_clk();
        check("rst_tx_dv", 32'(tx_dv), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_byte", 32'(tx_byte), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_to", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        wait_clk();

        // All four requesting from ptr 0: order 0,1,2,3, 82 cycles apart.
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        req      = 4'b1111;
        prev_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            wait_launch($sformatf("rr%0d", i));
            check($sformatf("rr%0d_ack", i), 32'(ack), 32'd1 << i);
            check($sformatf("rr%0d_byte", i), 32'(tx_byte), 32'(req_data[i]));
            if (i > 0) begin
                check($sformatf("rr%0d_gap", i), 32'(launch_cyc - prev_cyc), 32'd82);
            end
            prev_cyc = launch_cyc;
            wait_clk();
            req[i] = 1'b0;
        end
        wait_idle("rr");

        // Single request; a tx_done pulse sampled in SEND must be ignored.
        req_data[2] = 8'hA5;
        req         = 4'b0100;
        wait_clk();
        check("one_dv", 32'(tx_dv), 32'd1);
        check("one_ack", 32'(ack), 32'b0100);
        check("one_byte", 32'(tx_byte), 32'hA5);
        check("one_busy", 32'(busy), 32'd1);
        launch_cyc = cyc;
        force_done = 1'b1;
        wait_clk();
        force_done = 1'b0;
        check("one_dv_low", 32'(tx_dv), 32'd0);
        check("one_ack_low", 32'(ack), 32'd0);
        req = 4'b0000;
        wait_idle("one");
        check("one_busy_len", 32'(cyc - launch_cyc), 32'd81);
        check("one_byte_hold", 32'(tx_byte), 32'hA5);

        // Fairness: 0 and 2 held continuously, ptr starts at 3.
        req_data[0] = 8'h55;
        req_data[2] = 8'h77;
        req         = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            wait_launch($sformatf("fair%0d", i));
            check($sformatf("fair%0d_ack", i), 32'(ack), (i % 2 == 0) ? 32'b0001 : 32'b0100);
            check($sformatf("fair%0d_byte", i), 32'(tx_byte), (i % 2 == 0) ? 32'h55 : 32'h77);
            wait_clk();
        end
        req = 4'b0000;
        wait_idle("fair");

        // New req[3] arriving in the tx_done cycle launches two cycles after tx_done.
        req_data[1] = 8'h99;
        req_data[3] = 8'hC3;
        req         = 4'b0010;
        wait_launch("pre");
        check("pre_ack", 32'(ack), 32'b0010);
        wait_clk();
        req = 4'b0000;
        for (int n = 0; n < 300 && tx_done !== 1'b1; n++) wait_clk();
        check("done_seen", 32'(tx_done), 32'd1);
        mark_cyc = cyc;
        req      = 4'b1000;
        wait_launch("b2b");
        check("b2b_gap", 32'(launch_cyc - mark_cyc), 32'd2);
        check("b2b_ack", 32'(ack), 32'b1000);
        check("b2b_byte", 32'(tx_byte), 32'hC3);
        wait_clk();
        req = 4'b0000;
        wait_idle("b2b");

        // Transmitter never answers; requester 2 is left pending behind requester 1.
        model_en    = 1'b0;
        req_data[1] = 8'h3C;
        req_data[2] = 8'h5A;
        req         = 4'b0110;
        wait_launch("to");
        check("to_ack", 32'(ack), 32'b0010);
        prev_cyc = launch_cyc;
        wait_clk();
        req = 4'b0100;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        for (int n = 0; n < 300 && timeout_err !== 1'b1; n++) wait_clk();
        check("to_pulse", 32'(timeout_err), 32'd1);
        check("to_delay", 32'(cyc - prev_cyc), 32'd96);
        mark_cyc = cyc;
        model_en = 1'b1;
        wait_clk();
        check("to_pulse_len", 32'(timeout_err), 32'd0);
        check("to_idle", 32'(busy), 32'd0);
`else
        saw_to = 1'b0;
        for (int n = 0; n < 150; n++) begin
            wait_clk();
            saw_to |= timeout_err;
        end
        check("to_none", 32'(saw_to), 32'd0);
        check("to_stuck", 32'(busy), 32'd1);
        model_en   = 1'b1;
        force_done = 1'b1;
        mark_cyc   = cyc;
        wait_clk();
        force_done = 1'b0;
`endif
        wait_launch("to_next");
        check("to_next_gap", 32'(launch_cyc - mark_cyc), 32'd2);
        check("to_next_ack", 32'(ack), 32'b0100);
        check("to_next_byte", 32'(tx_byte), 32'h5A);
        prev_cyc = launch_cyc;
        wait_clk();

        // Reset 40 cycles into the frame; ptr is 3 beforehand, so serving 0 proves it cleared.
        req_data[0] = 8'hE1;
        req_data[3] = 8'hE4;
        req         = 4'b1001;
        while (cyc - prev_cyc < 40) wait_clk();
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_byte", 32'(tx_byte), 32'd0);
        check("mid_rst_dv", 32'(tx_dv), 32'd0);
        check("mid_rst_ack", 32'(ack), 32'd0);
        check("mid_rst_to", 32'(timeout_err), 32'd0);
        repeat (3) wait_clk();
        rst_n = 1'b1;
        wait_clk();
        check("post_rst_dv", 32'(tx_dv), 32'd1);
        check("post_rst_ack", 32'(ack), 32'b0001);
        check("post_rst_byte", 32'(tx_byte), 32'hE1);
        wait_clk();
        req = 4'b0000;
        wait_idle("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte requesters. It sits between the requesters and the transmitter core. Each cycle it picks at most one pending requester and launches its byte with a one-cycle `tx_dv` strobe. It then holds off further launches until the transmitter reports frame completion. It is the transmit-side counterpart of the receiver and uses the same bit timing (`CLKS_PER_BIT`).

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `CLKS_PER_BIT`, default 8: clocks per UART bit; used only for the timeout.
- `TIMEOUT_CYCLES`, default `CLKS_PER_BIT*12`: maximum wait for `tx_done` after launch.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req`, input, `NUM_REQ`: per-requester byte pending; held until its `ack`.
- `req_data`, input, `NUM_REQ` x 8 (packed `[NUM_REQ-1:0][7:0]`): per-requester byte; stable while `req` is high.
- `ack`, output, `NUM_REQ`: one-hot, one-cycle pulse; byte of that requester accepted.
- `tx_dv`, output, 1: one-cycle launch strobe to the transmitter.
- `tx_byte`, output, 8: byte to the transmitter; valid when `tx_dv` is high, held until the next launch.
- `tx_done`, input, 1: one-cycle pulse from the transmitter at end of stop bit.
- `busy`, output, 1: high in SEND and WAIT.
- `timeout_err`, output, 1: one-cycle pulse on watchdog expiry (see Configuration).

## Operation
- FSM states and transitions:
  - IDLE: if `|req`, then pick a winner, go to SEND. Otherwise stay in IDLE.
  - SEND: unconditional, go to WAIT.
  - WAIT: on `tx_done`, go to IDLE. On timeout (if enabled), go to IDLE.
- Arbitration: rotating priority starting at `ptr`. The winner is the first set bit of `req` at index `ptr`, `ptr+1`, … modulo `NUM_REQ`.
- `ptr` updates to winner+1 (mod `NUM_REQ`) on the IDLE→SEND edge. Reset value of `ptr` is 0.
- On the IDLE→SEND edge, the following are registered together: `tx_byte <= req_data[winner]`, `ack[winner] <= 1`, `tx_dv <= 1`.
  - `ack` and `tx_dv` are therefore high during SEND only.
- A requester drops or updates `req`/`req_data` at the earliest in the cycle after its `ack`.
- `req` deasserting while in SEND or WAIT has no effect on the current frame.
- `tx_done` outside WAIT is ignored.
- `tx_done` and a timeout in the same cycle: `tx_done` wins and no `timeout_err` is issued.
- A requester keeping `req` high after `ack` is treated as a new byte. It is served again only after all other pending requesters.

## Timing
- Reset values: `ack`=0, `tx_dv`=0, `tx_byte`=8'h00, `busy`=0, `timeout_err`=0, state=IDLE, `ptr`=0, timeout counter=0.
- Reset asserted mid-frame: immediate return to IDLE and all outputs to reset values. The byte in flight is neither re-sent nor flagged.
- Latency: `req` high in IDLE at edge k gives `tx_dv`/`ack` high for cycle k..k+1.
- `tx_done` sampled at edge t gives IDLE at t+1. The next `tx_dv` appears at t+2 at the earliest.
- Minimum launch-to-launch spacing is therefore frame time + 2 cycles.
- `busy` rises with `tx_dv` and falls the cycle after `tx_done` is sampled.

## Configuration
- Macro: `UART_TX_SCHED_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle; width is `$clog2(TIMEOUT_CYCLES+1)`.
  - When the count reaches `TIMEOUT_CYCLES` without `tx_done`: pulse `timeout_err` for one cycle and return to IDLE.
- Undefined:
  - No counter.
  - `timeout_err` is tied to 0.
  - WAIT exits only on `tx_done`.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `tx_sched_state_e` (IDLE, SEND, WAIT);
  - the default `CLKS_PER_BIT` constant, shared with the receiver and transmitter.
- Sub-module `uart_rr_pick`: combinational rotate-and-priority-encode.
  - Inputs: `req`, `ptr`.
  - Outputs: `any`, `winner` index.

## Test plan
Setup for all scenarios: `NUM_REQ`=4, `CLKS_PER_BIT`=8, transmitter model pulses `tx_done` 80 cycles after `tx_dv`.
- Single request: `req`=4'b0100, byte 8'hA5 → `ack`=4'b0100 and `tx_dv` one cycle later, `tx_byte`=8'hA5, `busy` high for 81 cycles.
- All four requesting, bytes 8'h10/8'h21/8'h32/8'h43, `req` held until each `ack` → launch order 0,1,2,3. Each launch is 82 cycles after the previous one.
- Fairness: requesters 0 and 2 keep `req` high continuously → launches alternate 0,2,0,2. Neither is served twice in a row.
- `tx_done` same cycle as new `req`[3] → `tx_dv` exactly two cycles after `tx_done`.
- Timeout, with macro defined: model never pulses `tx_done` → `timeout_err` pulse 96 cycles after SEND, then IDLE. The next pending byte launches two cycles later. Without the macro: the FSM stays in WAIT and `timeout_err` stays 0.
- Reset mid-frame: deassert `rst_n` 40 cycles into a frame → all outputs return to 0 immediately. After release, the first launch serves requester 0.
